// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and shift-direction constants for seq_alu.
package alu_pkg;

    localparam logic [2:0] OP_FWD   = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_MUL   = 3'b100;
    localparam logic [2:0] OP_SHIFT = 3'b101;
    localparam logic [2:0] OP_SAR   = 3'b110;
    localparam logic [2:0] OP_ROR   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MULT = 2'd2
    } state_t;

    localparam logic SHIFT_LEFT  = 1'b0;
    localparam logic SHIFT_RIGHT = 1'b1;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, product truncated to WIDTH bits.
module seq_multiplier #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] PRODUCT,
    output logic             LAST
);

    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

    logic               run;
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   partial;

    // PRODUCT already includes the current iteration so the final value is
    // available to the caller on the same edge the last bit is consumed.
    always_comb begin
        partial = multiplier[cnt] ? (multiplicand << cnt) : '0;
        PRODUCT = acc + partial;
        LAST    = run && (cnt == CNT_LAST);
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            run <= 1'b0;
            cnt <= '0;
            acc <= '0;
        end else if (LOAD) begin
            run <= 1'b1;
            cnt <= '0;
            acc <= '0;
        end else if (run) begin
            acc <= PRODUCT;
            cnt <= cnt + 1'b1;
            if (LAST) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Clocked ALU with START/DONE handshake; multiply runs iteratively, other ops take one cycle.
// state   | meaning
// IDLE    | waiting for START, BUSY low
// EXEC    | single-cycle op, result written on next edge
// MULT    | shift-add multiply in progress
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             START,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic [2:0]       SELECT,
    input  logic             SHIFT_DIRECTION,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] OUTPUT,
    output logic             ZERO,
    output logic             CARRY
);

    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH[WIDTH-1:0];

    state_t           state, state_next;
    logic [WIDTH-1:0] op1, op2;
    logic [2:0]       op_sel;
    logic             op_dir;
    logic             accept, complete, mul_load, mul_last;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] exec_result;
    logic             exec_carry;

    function automatic logic [WIDTH-1:0] shift_logical(input logic [WIDTH-1:0] a,
                                                       input logic [WIDTH-1:0] b,
                                                       input logic             dir);
        logic [WIDTH-1:0] r;
        r = '0;
        case (dir)
            SHIFT_LEFT:  r = a << b;
            SHIFT_RIGHT: r = a >> b;
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] shift_arith(input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b);
        return $signed(a) >>> b;
    endfunction

    function automatic logic [WIDTH-1:0] rotate_right(input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b);
        logic [SHAMT_W-1:0] amt;
        logic [2*WIDTH-1:0] dbl;
        amt = SHAMT_W'(b % WIDTH_V);
        dbl = {a, a} >> amt;
        return dbl[WIDTH-1:0];
    endfunction

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (START) state_next = (SELECT == OP_MUL) ? ST_MULT : ST_EXEC;
            ST_EXEC: state_next = ST_IDLE;
            ST_MULT: if (mul_last) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        BUSY     = (state != ST_IDLE);
        accept   = (state == ST_IDLE) && START;
        mul_load = accept && (SELECT == OP_MUL);
        complete = (state == ST_EXEC) || ((state == ST_MULT) && mul_last);
    end

    seq_multiplier #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_mult (
        .CLK          (CLK),
        .RESETN       (RESETN),
        .LOAD         (mul_load),
        .multiplicand (op1),
        .multiplier   (op2),
        .PRODUCT      (mul_product),
        .LAST         (mul_last)
    );

    always_comb begin
        sum         = {1'b0, op1} + {1'b0, op2};
        exec_result = '0;
        exec_carry  = 1'b0;
        case (op_sel)
            OP_FWD:   exec_result = op2;
            OP_ADD: begin
                exec_result = sum[WIDTH-1:0];
                exec_carry  = sum[WIDTH];
            end
            OP_AND:   exec_result = op1 & op2;
            OP_OR:    exec_result = op1 | op2;
            OP_MUL:   exec_result = mul_product;
            OP_SHIFT: exec_result = shift_logical(op1, op2, op_dir);
            OP_SAR:   exec_result = shift_arith(op1, op2);
            OP_ROR:   exec_result = rotate_right(op1, op2);
            default:  exec_result = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            op1    <= '0;
            op2    <= '0;
            op_sel <= OP_FWD;
            op_dir <= SHIFT_LEFT;
            OUTPUT <= '0;
            ZERO   <= 1'b1;
            CARRY  <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            DONE <= complete;
            if (accept) begin
                op1    <= DATA1;
                op2    <= DATA2;
                op_sel <= SELECT;
                op_dir <= SHIFT_DIRECTION;
            end
            if (complete) begin
                OUTPUT <= exec_result;
                ZERO   <= (exec_result == '0);
                CARRY  <= exec_carry;
            end
        end
    end

endmodule
